// File: rtl/schoolbook_unload.sv
// Unloads a wide multiplier product as a stream of W-bit words, least significant word first.
// Capture is triggered by prod_valid or, when AUTO is set, once LATENCY edges after reset release.
module schoolbook_unload #(
    parameter int PW      = 1142,
    parameter int W       = 64,
    parameter int LATENCY = 572,
    parameter int AUTO    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] prod,
    input  logic          prod_valid,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          overrun
);

    localparam int NW = (PW + W - 1) / W;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int TW = $clog2(LATENCY + 2);

    localparam logic IDLE   = 1'b0;
    localparam logic STREAM = 1'b1;

    logic              state;
    logic [IW-1:0]     idx;
    logic [TW-1:0]     tcnt;
    logic [NW*W-1:0]   shadow;
    logic [NW*W-1:0]   prod_ext;
    logic              auto_fire;
    logic              trigger;
    logic              last_word;

    assign auto_fire = (AUTO != 0) && (tcnt == TW'(LATENCY));
    assign trigger   = prod_valid || auto_fire;
    assign last_word = (idx == IW'(NW - 1));

    // Zero-pad the product up to a whole number of output words.
    always_comb begin
        prod_ext         = '0;
        prod_ext[PW-1:0] = prod;
    end

    // The timer stops one past LATENCY so the self-timed trigger fires only once per release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (tcnt != TW'(LATENCY + 1)) begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // A trigger while streaming, including on the last-word edge, is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= STREAM;
                        idx   <= '0;
                    end
                end
                STREAM: begin
                    if (trigger) begin
                        overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        if (last_word) begin
                            state <= IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && (state == IDLE) && trigger) begin
            shadow <= prod_ext;
        end
    end

    assign busy      = (state == STREAM);
    assign out_valid = busy;
    assign out_last  = busy && last_word;
    assign out_data  = busy ? shadow[W*idx +: W] : '0;

endmodule

// File: tb/tb_schoolbook_unload.sv
// Self-checking bench for schoolbook_unload: vector table, hand-written corner sequences
// and a randomized run against a word-count reference model.
module tb_schoolbook_unload;

    localparam int PW      = 1142;
    localparam int W       = 64;
    localparam int LATENCY = 572;
    localparam int NW      = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] prod;
    logic          prod_valid;
    logic          out_ready;

    logic [W-1:0]  out_data,  out_data_m;
    logic          out_valid, out_valid_m;
    logic          out_last,  out_last_m;
    logic          busy,      busy_m;
    logic          overrun,   overrun_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    schoolbook_unload #(.PW(PW), .W(W), .LATENCY(LATENCY), .AUTO(1)) dut (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .overrun(overrun)
    );

    schoolbook_unload #(.PW(PW), .W(W), .LATENCY(LATENCY), .AUTO(0)) dut_manual (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid),
        .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_last(out_last_m), .busy(busy_m), .overrun(overrun_m)
    );

    // Reference model: index 0 is the AUTO=1 instance, index 1 the AUTO=0 instance.
    logic [PW-1:0] m_prod  [2];
    int            m_left  [2];
    bit            m_ovr   [2];
    int            m_timer [2];

    typedef struct {
        bit rst, pv, rdy, alt;
        bit ev, el, eb, eo;
        int eidx;
    } vec_t;

    vec_t          tbl[$];
    logic [PW-1:0] pat_prod;
    logic [PW-1:0] ones_prod;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [W-1:0] pat_word(input int i);
        return {16'hC0DE, 8'(i), 8'h5A, 32'h9E37_79B9 ^ 32'(i)};
    endfunction

    function automatic logic [W-1:0] pat_expected(input int i);
        logic [W-1:0] w;
        w = pat_word(i);
        if (i == NW - 1) w = w & 64'h003F_FFFF_FFFF_FFFF;
        return w;
    endfunction

    function automatic logic [PW-1:0] rand_prod();
        logic [1151:0] t;
        for (int i = 0; i < 36; i++) t[32*i +: 32] = $urandom;
        return t[PW-1:0];
    endfunction

    function automatic logic [W-1:0] model_word(input int m);
        logic [PW-1:0] t;
        if (m_left[m] == 0) return '0;
        t = m_prod[m] >> (W * (NW - m_left[m]));
        return t[W-1:0];
    endfunction

    task automatic model_step(input bit r, input bit pv, input bit rdy, input logic [PW-1:0] p);
        bit trig;
        for (int m = 0; m < 2; m++) begin
            if (!r) begin
                m_left[m]  = 0;
                m_ovr[m]   = 1'b0;
                m_timer[m] = 0;
            end else begin
                trig = pv || ((m == 0) && (m_timer[m] == LATENCY));
                if (m_left[m] > 0) begin
                    if (trig) m_ovr[m] = 1'b1;
                    if (rdy) m_left[m]--;
                end else if (trig) begin
                    m_prod[m] = p;
                    m_left[m] = NW;
                end
                if (m_timer[m] < LATENCY + 1) m_timer[m]++;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit pv, input bit rdy, input logic [PW-1:0] p);
        rst        = r;
        prod_valid = pv;
        out_ready  = rdy;
        prod       = p;
        model_step(r, pv, rdy, p);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        checkOutput({tag, " valid"},   64'(out_valid),   64'(m_left[0] > 0));
        checkOutput({tag, " data"},    out_data,         model_word(0));
        checkOutput({tag, " last"},    64'(out_last),    64'(m_left[0] == 1));
        checkOutput({tag, " busy"},    64'(busy),        64'(m_left[0] > 0));
        checkOutput({tag, " overrun"}, 64'(overrun),     64'(m_ovr[0]));
        checkOutput({tag, " m_valid"}, 64'(out_valid_m), 64'(m_left[1] > 0));
        checkOutput({tag, " m_data"},  out_data_m,       model_word(1));
        checkOutput({tag, " m_last"},  64'(out_last_m),  64'(m_left[1] == 1));
        checkOutput({tag, " m_busy"},  64'(busy_m),      64'(m_left[1] > 0));
        checkOutput({tag, " m_ovr"},   64'(overrun_m),   64'(m_ovr[1]));
    endtask

    function automatic void add_row(input bit r, input bit pv, input bit rdy, input bit alt,
                                    input bit ev, input bit el, input bit eb, input bit eo, input int eidx);
        vec_t v;
        v.rst = r; v.pv = pv; v.rdy = rdy; v.alt = alt;
        v.ev = ev; v.el = el; v.eb = eb; v.eo = eo; v.eidx = eidx;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [NW*W-1:0] pat_full;
        logic [PW-1:0]   p;
        logic [W-1:0]    exp_data;
        int              e;

        for (int i = 0; i < NW; i++) pat_full[W*i +: W] = pat_word(i);
        pat_prod  = pat_full[PW-1:0];
        ones_prod = '1;

        // Reset, capture, stalls, overrun mid-stream and on the last edge, then reset again.
        add_row(0, 0, 1, 0,  0, 0, 0, 0, -1);
        add_row(1, 1, 0, 0,  1, 0, 1, 0,  0);
        add_row(1, 0, 0, 1,  1, 0, 1, 0,  0);
        add_row(1, 0, 1, 1,  1, 0, 1, 0,  1);
        add_row(1, 0, 0, 1,  1, 0, 1, 0,  1);
        add_row(1, 0, 0, 1,  1, 0, 1, 0,  1);
        add_row(1, 0, 1, 1,  1, 0, 1, 0,  2);
        add_row(1, 1, 1, 1,  1, 0, 1, 1,  3);
        for (int i = 4; i < NW; i++) add_row(1, 0, 1, 1,  1, (i == NW - 1), 1, 1, i);
        add_row(1, 0, 0, 1,  1, 1, 1, 1, 17);
        add_row(1, 1, 1, 1,  0, 0, 0, 1, -1);
        add_row(1, 0, 1, 1,  0, 0, 0, 1, -1);
        add_row(0, 0, 1, 1,  0, 0, 0, 0, -1);

        rst = 1'b0; prod_valid = 1'b0; out_ready = 1'b0; prod = '0;
        @(negedge clk);
        applyStimulus(0, 0, 0, '0);

        foreach (tbl[k]) begin
            applyStimulus(tbl[k].rst, tbl[k].pv, tbl[k].rdy, tbl[k].alt ? ones_prod : pat_prod);
            exp_data = (tbl[k].eidx < 0) ? '0 : pat_expected(tbl[k].eidx);
            checkOutput($sformatf("row%0d valid", k),   64'(out_valid),   64'(tbl[k].ev));
            checkOutput($sformatf("row%0d last", k),    64'(out_last),    64'(tbl[k].el));
            checkOutput($sformatf("row%0d busy", k),    64'(busy),        64'(tbl[k].eb));
            checkOutput($sformatf("row%0d overrun", k), 64'(overrun),     64'(tbl[k].eo));
            checkOutput($sformatf("row%0d data", k),    out_data,         exp_data);
            checkOutput($sformatf("row%0d m_valid", k), 64'(out_valid_m), 64'(tbl[k].ev));
            checkOutput($sformatf("row%0d m_data", k),  out_data_m,       exp_data);
        end

        // All-ones product through a manual capture.
        applyStimulus(1, 1, 1, ones_prod);
        for (int k = 0; k < NW; k++) begin
            exp_data = (k == NW - 1) ? 64'h003F_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
            checkOutput($sformatf("ones word%0d", k), out_data_m, exp_data);
            checkOutput($sformatf("ones last%0d", k), 64'(out_last_m), 64'(k == NW - 1));
            check_model("ones");
            applyStimulus(1, 0, 1, ones_prod);
        end
        checkOutput("ones busy after last", 64'(busy_m), 64'(0));
        check_model("ones end");

        // Self-timed capture latency and contents.
        applyStimulus(0, 0, 1, PW'(1));
        e = 0;
        do begin
            applyStimulus(1, 0, 1, PW'(1));
            e++;
        end while (!out_valid && e < 700);
        checkOutput("auto latency", 64'(e), 64'(LATENCY + 1));
        checkOutput("auto manual idle", 64'(out_valid_m), 64'(0));
        for (int k = 0; k < NW; k++) begin
            checkOutput($sformatf("auto word%0d", k), out_data, (k == 0) ? 64'h1 : 64'h0);
            checkOutput($sformatf("auto last%0d", k), 64'(out_last), 64'(k == NW - 1));
            check_model("auto");
            applyStimulus(1, 0, 1, PW'(1));
        end
        checkOutput("auto done", 64'(out_valid), 64'(0));

        // Abort mid-stream with overrun set, then a fresh auto stream after release.
        applyStimulus(0, 0, 1, pat_prod);
        e = 0;
        do begin
            applyStimulus(1, 0, 0, pat_prod);
            e++;
        end while (!out_valid && e < 700);
        checkOutput("abort latency", 64'(e), 64'(LATENCY + 1));
        for (int k = 0; k < 6; k++) applyStimulus(1, (k == 2), 1, pat_prod);
        checkOutput("abort at word6", out_data, pat_expected(6));
        checkOutput("abort overrun set", 64'(overrun), 64'(1));
        applyStimulus(0, 0, 1, pat_prod);
        checkOutput("abort valid", 64'(out_valid), 64'(0));
        checkOutput("abort busy", 64'(busy), 64'(0));
        checkOutput("abort overrun", 64'(overrun), 64'(0));
        p = rand_prod();
        e = 0;
        do begin
            applyStimulus(1, 0, 0, p);
            e++;
            if (e < 5) check_model("post abort");
        end while (!out_valid && e < 700);
        checkOutput("rearm latency", 64'(e), 64'(LATENCY + 1));
        checkOutput("rearm word0", out_data, p[63:0]);
        check_model("rearm");

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            applyStimulus($urandom_range(0, 999) != 0, $urandom_range(0, 59) == 0,
                          1'($urandom_range(0, 1)), rand_prod());
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/schoolbook_unload.md
SCHOOLBOOK_UNLOAD -- requirements
Module: schoolbook_unload

Parameters
REQ-001 SHALL provide parameter PW, default 1142: product width in bits.
REQ-002 SHALL provide parameter W, default 64: output word width in bits.
REQ-003 SHALL provide parameter LATENCY, default 572: number of clock edges after reset release until the upstream product is final.
REQ-004 SHALL provide parameter AUTO, default 1: 1 enables the self-timed capture trigger, 0 disables it.
REQ-005 SHALL derive NW = ceil(PW/W), which is 18 at the defaults.

Interface
REQ-006 clk  in  1  sole clock; all state updates occur on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 prod  in  PW  product from the upstream multiplier.
REQ-009 prod_valid  in  1  one-cycle capture strobe.
REQ-010 out_data  out  W  current output word.
REQ-011 out_valid  out  1  out_data is valid.
REQ-012 out_ready  in  1  downstream accepts the word.
REQ-013 out_last  out  1  current word is word NW-1.
REQ-014 busy  out  1  a product is captured and not yet fully drained.
REQ-015 overrun  out  1  sticky: a trigger arrived while busy.

Function
REQ-016 SHALL keep a timer tcnt that increments on every edge with rst=1 and saturates at LATENCY+1.
REQ-017 With AUTO=1, a capture trigger SHALL occur on the single edge where tcnt==LATENCY; this trigger fires exactly once per reset release.
REQ-018 A capture trigger SHALL also occur on any edge where prod_valid=1, regardless of AUTO.
REQ-019 The FSM SHALL have two states, IDLE and STREAM; the reset state is IDLE.
REQ-020 IDLE + trigger: register prod into the shadow register, set word index idx=0, go to STREAM; out_valid=1 from the next cycle.
REQ-021 In STREAM, out_data SHALL equal shadow[W*idx +: W], with bits above PW-1 zero-padded (word 17 = {10'b0, prod[1141:1088]}).
REQ-022 out_last SHALL be 1 exactly when out_valid=1 and idx==NW-1.
REQ-023 A transfer SHALL occur on an edge with out_valid=1 and out_ready=1; idx then increments.
REQ-024 Without a transfer, out_data, out_last and out_valid SHALL hold stable.
REQ-025 On a transfer of the last word, the FSM SHALL go to IDLE and out_valid SHALL be 0 in the next cycle.
REQ-026 There SHALL be no bubble between words; back-to-back transfers run at one word per cycle.
REQ-027 Trigger in STREAM: the trigger SHALL be ignored, the shadow register left unchanged, and overrun set to 1, which stays 1 until reset.
REQ-028 Trigger on the same edge as the last-word transfer: the trigger SHALL be treated as arriving during STREAM, i.e. ignored with overrun set; no same-cycle restart.
REQ-029 busy SHALL equal (state==STREAM).
REQ-030 prod SHALL be sampled only on a capture edge; upstream changes afterwards SHALL not affect the output.
REQ-031 out_ready SHALL be ignored in IDLE.

Reset
REQ-032 rst=0 at an edge SHALL clear: state=IDLE, idx=0, tcnt=0, out_valid=0, out_last=0, busy=0, overrun=0, out_data=0.
REQ-033 The shadow register need not be reset.
REQ-034 Reset asserted mid-STREAM SHALL abort the stream: out_valid=0 after that edge, and no further words are emitted.
REQ-035 After reset release, the AUTO trigger SHALL re-arm.

Verification
REQ-036 AUTO=1, defaults, out_ready=1, prod held at 1142'h1 from reset release -> out_valid rises the cycle after edge 573; 18 words emitted; word0=64'h1, words 1-17=0; out_last only on word 17.
REQ-037 AUTO=0, prod_valid pulse with prod = all ones -> words 0-16 = 64'hFFFF_FFFF_FFFF_FFFF, word 17 = 64'h003F_FFFF_FFFF_FFFF, last on word 17, busy drops the cycle after the last transfer.
REQ-038 out_ready toggled 1,0,0,1,... during a stream -> out_data and out_last stable during stalls; no word lost or duplicated; exactly 18 transfers.
REQ-039 Second prod_valid during STREAM and another on the last-word edge -> overrun=1, streamed data unchanged, FSM returns to IDLE.
REQ-040 rst=0 asserted after word 5 is accepted -> out_valid=0, busy=0, overrun=0 next cycle; after release with AUTO=1 a fresh stream begins at word 0.
